// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares the single-port pixel RAM between scanout reads and FIFO-buffered processor writes drained during blanking
module vga_fb_arbiter #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int PIXELS      = 307200,
    parameter int VBLANK_ONLY = 0
) (
    input  logic                          iVGA_CLK,
    input  logic                          iRST_n,
    input  logic                          blank_n,
    input  logic                          vs,
    input  logic [ADDR_W-1:0]             scan_addr,
    input  logic                          wr_valid,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    input  logic                          err_clr,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_wdata,
    output logic                          ram_we,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_done,
    output logic                          err_oob
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(PIXELS);

    typedef enum logic [1:0] {ACTIVE, HBLANK, VBLANK} state_t;

    state_t                     state, next_state;
    logic [ADDR_W+DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [ADDR_W-1:0]          head_addr;
    logic [DATA_W-1:0]          head_data;
    logic                       in_range, push, oob, pop, window;

    assign {head_addr, head_data} = mem[rd_ptr];
    assign in_range = {1'b0, wr_addr} < LIMIT;
    assign wr_ready = fifo_level != DEPTH;
    assign push     = wr_valid & wr_ready & in_range;
    assign oob      = wr_valid & wr_ready & ~in_range;
    assign window   = state == VBLANK || (VBLANK_ONLY == 0 && state == HBLANK);
    // blank_n is checked live so the lag cycle of the state register never steals the first active pixel
    assign pop      = ~blank_n & (fifo_level != '0) & window;

    // RAM port mux: scanout owns the address unless a queued write is draining
    always_comb begin
        ram_we    = pop;
        ram_addr  = pop ? head_addr : scan_addr;
        ram_wdata = head_data;
    end

    // Blanking tracker; VBLANK stays latched through the back porch until active video resumes
    always_comb begin
        next_state = state;
        case (state)
            ACTIVE:  next_state = !vs ? VBLANK : (!blank_n ? HBLANK : ACTIVE);
            HBLANK:  next_state = !vs ? VBLANK : (blank_n ? ACTIVE : HBLANK);
            VBLANK:  next_state = blank_n ? ACTIVE : VBLANK;
            default: next_state = ACTIVE;
        endcase
    end

    // State, FIFO pointers/occupancy, frame pulse and sticky out-of-range flag
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state      <= ACTIVE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            frame_done <= 1'b0;
            err_oob    <= 1'b0;
        end else begin
            state      <= next_state;
            wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
            fifo_level <= fifo_level + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
            frame_done <= next_state == VBLANK && state != VBLANK;
            err_oob    <= oob | (err_oob & ~err_clr);
        end
    end

    // FIFO storage holds {address, data}; no reset needed since occupancy gates every read
    always_ff @(posedge iVGA_CLK) begin
        if (push) mem[wr_ptr] <= {wr_addr, wr_data};
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: scoreboard-based checks of write queuing, blanking-gated draining, flow control and errors
module tb_vga_fb_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0, blank_n = 1'b1, vs = 1'b1, wr_valid = 1'b0, err_clr = 1'b0;
    logic [18:0] scan_addr = '0, wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ready0, ram_we0, frame_done0, err_oob0;
    logic        wr_ready1, ram_we1, frame_done1, err_oob1;
    logic [18:0] ram_addr0, ram_addr1;
    logic [7:0]  ram_wdata0, ram_wdata1;
    logic [3:0]  fifo_level0, fifo_level1;
    logic [26:0] sb [$];
    logic [26:0] exp_e;
    int          tests = 0, fails = 0, fd_cnt = 0, we_cnt = 0;

    vga_fb_arbiter dut0 (
        .iVGA_CLK(clk), .iRST_n(rst_n), .blank_n(blank_n), .vs(vs), .scan_addr(scan_addr),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready0),
        .err_clr(err_clr), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0), .ram_we(ram_we0),
        .fifo_level(fifo_level0), .frame_done(frame_done0), .err_oob(err_oob0)
    );

    vga_fb_arbiter #(.VBLANK_ONLY(1)) dut1 (
        .iVGA_CLK(clk), .iRST_n(rst_n), .blank_n(blank_n), .vs(vs), .scan_addr(scan_addr),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready1),
        .err_clr(err_clr), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_we(ram_we1),
        .fifo_level(fifo_level1), .frame_done(frame_done1), .err_oob(err_oob1)
    );

    always #5 clk = ~clk;

    // Scoreboard for dut0: compare each RAM write to the oldest accepted in-range request, then record new handshakes
    always @(negedge clk) begin
        if (rst_n && ram_we0) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_write: unexpected write addr %0d data %0h, want none", ram_addr0, ram_wdata0);
            end else begin
                exp_e = sb.pop_front();
                if ({ram_addr0, ram_wdata0} !== exp_e) begin
                    fails++;
                    $display("FAIL sb_write: got addr %0d data %0h, want addr %0d data %0h",
                             ram_addr0, ram_wdata0, exp_e[26:8], exp_e[7:0]);
                end
            end
        end
        if (rst_n && wr_valid && wr_ready0 && wr_addr < 19'd307200) sb.push_back({wr_addr, wr_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_valid = 1'b0; err_clr = 1'b0; blank_n = 1'b1; vs = 1'b1;
        rst_n = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; blank_n = 1'b1; vs = 1'b1; wr_valid = 1'b0; scan_addr = 19'd123;
        sb.delete();
        @(negedge clk);
        tests++; if (fifo_level0 !== 4'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", fifo_level0); end
        tests++; if (wr_ready0 !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", wr_ready0); end
        tests++; if (ram_we0 !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", ram_we0); end
        tests++; if (frame_done0 !== 1'b0) begin fails++; $display("FAIL reset_fd: got %b want 0", frame_done0); end
        tests++; if (err_oob0 !== 1'b0) begin fails++; $display("FAIL reset_oob: got %b want 0", err_oob0); end
        tests++; if (ram_addr0 !== 19'd123) begin fails++; $display("FAIL reset_addr: got %0d want 123", ram_addr0); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_drain_hblank();
        do_reset();
        scan_addr = 19'd5;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = 19'(10 * (i + 1)); wr_data = 8'(8'h11 * (i + 1));
            tick();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++; if (ram_we0 !== 1'b0) begin fails++; $display("FAIL active_we: got %b want 0", ram_we0); end
            tick();
        end
        @(negedge clk);
        tests++; if (fifo_level0 !== 4'd3) begin fails++; $display("FAIL queued_level: got %0d want 3", fifo_level0); end
        tick();
        blank_n = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (ram_we0 !== 1'b1) begin fails++; $display("FAIL hblank_we%0d: got %b want 1", i, ram_we0); end
            tests++; if (ram_addr0 !== 19'(10 * (i + 1))) begin fails++; $display("FAIL hblank_addr%0d: got %0d want %0d", i, ram_addr0, 10 * (i + 1)); end
            tick();
        end
        @(negedge clk);
        tests++; if (ram_we0 !== 1'b0 || fifo_level0 !== 4'd0) begin fails++; $display("FAIL drained: we %b level %0d want 0 0", ram_we0, fifo_level0); end
        tick();
        blank_n = 1'b1;
        tick();
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL sb_empty: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_vblank_only();
        do_reset();
        wr_valid = 1'b1; wr_addr = 19'd40; wr_data = 8'h44;
        tick();
        wr_valid = 1'b0; blank_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++; if (ram_we1 !== 1'b0) begin fails++; $display("FAIL vo_hblank_we%0d: got %b want 0", i, ram_we1); end
            tick();
        end
        tests++; if (fifo_level1 !== 4'd1) begin fails++; $display("FAIL vo_level: got %0d want 1", fifo_level1); end
        blank_n = 1'b1;
        tick(); tick();
        vs = 1'b0; blank_n = 1'b0;
        tick();
        @(negedge clk);
        tests++; if (ram_we1 !== 1'b1 || ram_addr1 !== 19'd40 || ram_wdata1 !== 8'h44) begin
            fails++; $display("FAIL vo_vblank_write: we %b addr %0d data %0h want 1 40 44", ram_we1, ram_addr1, ram_wdata1);
        end
        tests++; if (frame_done1 !== 1'b1) begin fails++; $display("FAIL vo_frame_done: got %b want 1", frame_done1); end
        tick();
        fd_cnt = 0;
        run_phase(1'b0, 1'b0, 2); run_phase(1'b0, 1'b1, 3); run_phase(1'b1, 1'b1, 5);
        run_phase(1'b0, 1'b0, 4); run_phase(1'b0, 1'b1, 3); run_phase(1'b1, 1'b1, 2);
        tests++; if (fd_cnt != 1) begin fails++; $display("FAIL vo_fd_count: got %0d pulses want 1", fd_cnt); end
    endtask

    task automatic run_phase(input logic b, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            blank_n = b; vs = v;
            @(negedge clk);
            fd_cnt += int'(frame_done1);
            tick();
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; wr_addr = 19'(100 + i); wr_data = 8'(i);
            @(negedge clk);
            tests++; if (wr_ready0 !== 1'b1) begin fails++; $display("FAIL fill_ready%0d: got %b want 1", i, wr_ready0); end
            tick();
        end
        wr_addr = 19'd108; wr_data = 8'd8;
        @(negedge clk);
        tests++; if (wr_ready0 !== 1'b0 || fifo_level0 !== 4'd8) begin fails++; $display("FAIL full: ready %b level %0d want 0 8", wr_ready0, fifo_level0); end
        tick();
        @(negedge clk);
        tests++; if (fifo_level0 !== 4'd8) begin fails++; $display("FAIL stall_level: got %0d want 8", fifo_level0); end
        blank_n = 1'b0;
        tick();
        @(negedge clk);
        tests++; if (ram_we0 !== 1'b1 || wr_ready0 !== 1'b0 || fifo_level0 !== 4'd8) begin
            fails++; $display("FAIL full_pop: we %b ready %b level %0d want 1 0 8", ram_we0, wr_ready0, fifo_level0);
        end
        tick();
        @(negedge clk);
        tests++; if (ram_we0 !== 1'b1 || wr_ready0 !== 1'b1 || fifo_level0 !== 4'd7) begin
            fails++; $display("FAIL push_pop: we %b ready %b level %0d want 1 1 7", ram_we0, wr_ready0, fifo_level0);
        end
        tick();
        wr_valid = 1'b0;
        @(negedge clk);
        tests++; if (fifo_level0 !== 4'd7) begin fails++; $display("FAIL push_pop_level: got %0d want 7", fifo_level0); end
        for (int k = 0; k < 20 && fifo_level0 != 4'd0; k++) tick();
        tests++; if (fifo_level0 !== 4'd0) begin fails++; $display("FAIL full_drain: got %0d want 0", fifo_level0); end
        tick();
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL full_sb_empty: got %0d pending want 0", sb.size()); end
        blank_n = 1'b1;
        tick();
    endtask

    task automatic test_oob();
        do_reset();
        wr_valid = 1'b1; wr_addr = 19'd307200; wr_data = 8'h55;
        @(negedge clk);
        tests++; if (wr_ready0 !== 1'b1) begin fails++; $display("FAIL oob_ready: got %b want 1", wr_ready0); end
        tick();
        wr_valid = 1'b0;
        @(negedge clk);
        tests++; if (err_oob0 !== 1'b1 || fifo_level0 !== 4'd0) begin fails++; $display("FAIL oob_set: err %b level %0d want 1 0", err_oob0, fifo_level0); end
        tick();
        wr_valid = 1'b1; wr_addr = 19'd400000; err_clr = 1'b1;
        tick();
        wr_valid = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        tests++; if (err_oob0 !== 1'b1) begin fails++; $display("FAIL oob_set_wins: got %b want 1", err_oob0); end
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        tests++; if (err_oob0 !== 1'b0) begin fails++; $display("FAIL oob_clear: got %b want 0", err_oob0); end
        tick();
        wr_valid = 1'b1; wr_addr = 19'd307199; wr_data = 8'h66;
        tick();
        wr_valid = 1'b0;
        @(negedge clk);
        tests++; if (fifo_level0 !== 4'd1 || err_oob0 !== 1'b0) begin fails++; $display("FAIL last_pixel: level %0d err %b want 1 0", fifo_level0, err_oob0); end
        tick();
    endtask

    task automatic test_lag_cycle();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_addr = 19'(50 + 10 * i); wr_data = 8'(8'h5A + 8'h10 * i);
            tick();
        end
        wr_valid = 1'b0; blank_n = 1'b0;
        tick();
        blank_n = 1'b1; scan_addr = 19'd777;
        @(negedge clk);
        tests++; if (ram_we0 !== 1'b0 || ram_addr0 !== 19'd777) begin fails++; $display("FAIL lag_cycle: we %b addr %0d want 0 777", ram_we0, ram_addr0); end
        tests++; if (fifo_level0 !== 4'd2) begin fails++; $display("FAIL lag_level: got %0d want 2", fifo_level0); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1; wr_addr = 19'(200 + i); wr_data = 8'(8'hA0 + i);
            tick();
        end
        wr_valid = 1'b0; blank_n = 1'b0;
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        tests++; if (fifo_level0 !== 4'd5 || ram_we0 !== 1'b1) begin fails++; $display("FAIL pre_reset: level %0d we %b want 5 1", fifo_level0, ram_we0); end
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        tests++; if (ram_we0 !== 1'b0 || fifo_level0 !== 4'd0 || wr_ready0 !== 1'b1) begin
            fails++; $display("FAIL async_reset: we %b level %0d ready %b want 0 0 1", ram_we0, fifo_level0, wr_ready0);
        end
        tick(); tick();
        rst_n = 1'b1;
        we_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            vs = (i < 4);
            @(negedge clk);
            we_cnt += int'(ram_we0);
            tick();
        end
        tests++; if (we_cnt != 0 || fifo_level0 !== 4'd0) begin fails++; $display("FAIL stale_writes: %0d writes level %0d want 0 0", we_cnt, fifo_level0); end
        vs = 1'b1; blank_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_drain_hblank();
        test_vblank_only();
        test_full();
        test_oob();
        test_lag_cycle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
